mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 8, words per cache block fill (power of 2, 2..16).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 icache_miss  input  1  I-cache block-fill request, level, held until i_fill_done.
REQ-005 icache_addr  input  16  I-cache miss byte address.
REQ-006 dcache_miss  input  1  D-cache block-fill request, level, held until d_fill_done.
REQ-007 dcache_addr  input  16  D-cache miss/store byte address.
REQ-008 dcache_wr  input  1  D-cache single-word write-through request, level, held until wr_done.
REQ-009 dcache_wr_data  input  16  store data.
REQ-010 mem_data_out  input  16  read data from shared main memory.
REQ-011 mem_data_valid  input  1  mem_data_out valid this cycle (memory returns reads in issue order, fixed latency).
REQ-012 mem_addr  output  16  memory byte address.
REQ-013 mem_data_in  output  16  memory write data.
REQ-014 mem_enable  output  1  memory access this cycle.
REQ-015 mem_wr  output  1  access is a write.
REQ-016 fill_data  output  16  returned word, equals mem_data_out.
REQ-017 i_fill_valid / d_fill_valid  output  1 each  fill_data belongs to I / D fill.
REQ-018 fill_word  output  log2(BLOCK_WORDS)  word index within block of fill_data.
REQ-019 i_fill_done / d_fill_done / wr_done  output  1 each  one-cycle completion pulses.

Function
REQ-020 FSM states IDLE, FILL, WRITE; 1-bit owner register (I or D) valid in FILL.
REQ-021 In IDLE, grant priority: dcache_wr > dcache_miss > icache_miss (unless ARB_RR_EN); grant takes effect at next edge.
REQ-022 Block base = miss address with low log2(BLOCK_WORDS)+1 bits cleared; latched at grant.
REQ-023 FILL: issue counter drives mem_enable=1, mem_wr=0, mem_addr=base+2*k for k=0..BLOCK_WORDS-1 on consecutive cycles starting first FILL cycle; then mem_enable=0.
REQ-024 FILL: receive counter increments on each mem_data_valid; fill_word=receive count; owner's *_fill_valid=mem_data_valid.
REQ-025 On the BLOCK_WORDS-th valid word, owner's *_fill_done pulses same cycle; next state IDLE.
REQ-026 WRITE: exactly one cycle, mem_enable=1, mem_wr=1, mem_addr=dcache_addr with bit 0 cleared, mem_data_in=dcache_wr_data, wr_done=1; next state IDLE.
REQ-027 Minimum one IDLE cycle between transactions; no transaction overlap.
REQ-028 Requests deasserted mid-transaction do not abort it; transaction completes, done still pulses.
REQ-029 mem_data_valid in IDLE or WRITE ignored; all fill_valid outputs 0.
REQ-030 Counters wrap-free: issue count saturates at BLOCK_WORDS; receive count clears on entering FILL.
REQ-031 Outside WRITE, mem_wr=0 and mem_data_in=0; outside active issue, mem_addr=0.

Reset
REQ-032 rst_n low asynchronously forces IDLE, counters 0, owner I, base 0, all outputs 0.
REQ-033 Reset mid-FILL or mid-WRITE abandons transaction with no done pulse; first grant possible at first edge after rst_n rises.

Configuration
REQ-034 Macro ARB_RR_EN defined: when dcache_miss and icache_miss both pending (no dcache_wr), grant goes to the requester not granted the most recent fill (reset value: last=D, so I wins first tie); dcache_wr keeps top priority.
REQ-035 ARB_RR_EN undefined: fixed priority per REQ-021, I fill may starve.

Verification
REQ-036 icache_miss=1, icache_addr=0x1236, memory latency 4 -> mem_addr 0x1230..0x123E on 8 consecutive cycles, 8 i_fill_valid with fill_word 0..7, i_fill_done on 8th.
REQ-037 dcache_wr=1, addr 0x0041, data 0xBEEF -> one cycle mem_wr=1, mem_addr 0x0040, mem_data_in 0xBEEF, wr_done=1, back to IDLE.
REQ-038 icache_miss and dcache_miss asserted same cycle, held -> D fill first; without ARB_RR_EN I after D; with ARB_RR_EN repeated ties alternate I,D,I.
REQ-039 dcache_wr rises during I fill -> I fill finishes undisturbed, WRITE granted in following IDLE cycle.
REQ-040 rst_n pulsed low after 3rd fill word -> outputs 0 immediately, no done pulse, late mem_data_valid ignored, new request after release served from word 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one main-memory port between an I-cache and a D-cache. Block fills
//   are BLOCK_WORDS back-to-back reads, issued from the block base address.
//   The words are handed back to the owning cache as memory returns them.
//   D-cache stores are single-cycle write-through accesses.
//   Grant priority in IDLE: dcache_wr > dcache_miss > icache_miss.
//
// Optional feature (compile-time macro ARB_RR_EN):
//   When both caches miss at the same time and no store is pending, the grant
//   alternates between them, so the I-cache cannot be starved. Without the
//   macro the fixed priority above applies.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   icache_miss/icache_addr    I-cache fill request (level) and byte address
//   dcache_miss/dcache_addr    D-cache fill request (level) and byte address
//   dcache_wr/dcache_wr_data   D-cache store request (level) and store data
//   mem_data_out/valid         read return from memory (in order, fixed latency)
//   mem_addr/data_in/enable/wr memory command port
//   fill_data/fill_word        returned word and its index within the block
//   i_fill_valid/d_fill_valid  fill_data belongs to the I / D fill
//   i_fill_done/d_fill_done    last fill word delivered (one-cycle pulse)
//   wr_done                    store performed (one-cycle pulse)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           icache_miss,
  input  logic [15:0]                    icache_addr,
  input  logic                           dcache_miss,
  input  logic [15:0]                    dcache_addr,
  input  logic                           dcache_wr,
  input  logic [15:0]                    dcache_wr_data,
  input  logic [15:0]                    mem_data_out,
  input  logic                           mem_data_valid,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_data_in,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [15:0]                    fill_data,
  output logic                           i_fill_valid,
  output logic                           d_fill_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_done,
  output logic                           d_fill_done,
  output logic                           wr_done
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int BW_M1 = BLOCK_WORDS - 1;
  // A block spans 2*BLOCK_WORDS bytes, so the base clears CNT_W+1 low bits.
  localparam logic [15:0]      BASE_MASK = ~(16'(2 * BLOCK_WORDS) - 16'd1);
  localparam logic [CNT_W:0]   ISSUE_MAX = BLOCK_WORDS[CNT_W:0];
  localparam logic [CNT_W:0]   ISSUE_ONE = 1;
  localparam logic [CNT_W-1:0] RECV_ONE  = 1;
  localparam logic [CNT_W-1:0] RECV_LAST = BW_M1[CNT_W-1:0];

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [15:0]      base_q, base_d;
  logic [CNT_W:0]   issue_q, issue_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic             pick_d;
`ifdef ARB_RR_EN
  logic             last_q, last_d;   // owner of the most recent fill grant
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_I;
      base_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
`ifdef ARB_RR_EN
      last_q  <= OWN_D;               // I wins the first tie
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    base_d       = base_q;
    issue_d      = issue_q;
    recv_d       = recv_q;
    pick_d       = OWN_I;
`ifdef ARB_RR_EN
    last_d       = last_q;
`endif
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    fill_data    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_word    = '0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    wr_done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dcache_wr) begin
          state_d = S_WRITE;
        end else if (dcache_miss || icache_miss) begin
          pick_d = dcache_miss ? OWN_D : OWN_I;
`ifdef ARB_RR_EN
          if (dcache_miss && icache_miss) begin
            pick_d = ~last_q;
          end
          last_d = pick_d;
`endif
          owner_d = pick_d;
          base_d  = ((pick_d == OWN_D) ? dcache_addr : icache_addr) & BASE_MASK;
          issue_d = '0;
          recv_d  = '0;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        // Reads go out back to back; the issue counter stops at BLOCK_WORDS.
        if (issue_q < ISSUE_MAX) begin
          mem_enable = 1'b1;
          mem_addr   = base_q + 16'({issue_q, 1'b0});
          issue_d    = issue_q + ISSUE_ONE;
        end
        fill_data    = mem_data_out;
        fill_word    = recv_q;
        i_fill_valid = mem_data_valid && (owner_q == OWN_I);
        d_fill_valid = mem_data_valid && (owner_q == OWN_D);
        if (mem_data_valid) begin
          recv_d = recv_q + RECV_ONE;
          if (recv_q == RECV_LAST) begin
            i_fill_done = (owner_q == OWN_I);
            d_fill_done = (owner_q == OWN_D);
            recv_d      = '0;
            state_d     = S_IDLE;
          end
        end
      end

      S_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = {dcache_addr[15:1], 1'b0};
        mem_data_in = dcache_wr_data;
        wr_done     = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter (BLOCK_WORDS = 8). Stimulus pushes the
//   expected memory accesses and fill words into queues. A monitor pops and
//   compares them whenever the DUT drives the memory port or a fill word. The
//   memory model returns read data addr ^ 16'h5A5A with a latency of 4 cycles.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_miss, dcache_miss, dcache_wr;
  logic [15:0] icache_addr, dcache_addr, dcache_wr_data;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic [15:0] mem_addr, mem_data_in, fill_data;
  logic        mem_enable, mem_wr, i_fill_valid, d_fill_valid;
  logic [2:0]  fill_word;
  logic        i_fill_done, d_fill_done, wr_done;

  mem_arbiter #(.BLOCK_WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .dcache_wr(dcache_wr), .dcache_wr_data(dcache_wr_data),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_enable(mem_enable), .mem_wr(mem_wr),
    .fill_data(fill_data), .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_word(fill_word), .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [15:0] addr; logic [15:0] data; logic consec; } acc_t;
  typedef struct { logic d; logic [2:0] word; logic [15:0] data; logic done; } fil_t;
  typedef struct { int due; logic [15:0] data; } rd_t;

  acc_t acc_q[$];
  fil_t fil_q[$];
  rd_t  rd_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_rd_cyc = -10;
  int first_rd_cyc = -10;
  int last_wr_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: reads seen in a cycle return 4 cycles later, in order.
  initial begin
    mem_data_valid = 1'b0;
    mem_data_out   = '0;
    forever begin
      @(negedge clk);
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        mem_data_valid = 1'b1;
        mem_data_out   = rd_q[0].data;
        void'(rd_q.pop_front());
      end else begin
        mem_data_valid = 1'b0;
        mem_data_out   = '0;
      end
      if (mem_enable && !mem_wr) rd_q.push_back('{cyc + 4, mem_addr ^ 16'h5A5A});
    end
  end

  // Monitor
  initial begin
    acc_t a;
    fil_t f;
    forever begin
      @(negedge clk);
      #1;
      if (mem_enable) begin
        vectors++;
        if (acc_q.size() == 0) begin
          miscompares++;
          $display("FAIL access_unexpected: got wr=%b addr=%h, required none", mem_wr, mem_addr);
        end else begin
          a = acc_q.pop_front();
          if ({mem_wr, mem_addr, mem_data_in, wr_done} != {a.wr, a.addr, a.data, a.wr}) begin
            miscompares++;
            $display("FAIL access: got wr=%b addr=%h din=%h wr_done=%b, required wr=%b addr=%h din=%h wr_done=%b",
                     mem_wr, mem_addr, mem_data_in, wr_done, a.wr, a.addr, a.data, a.wr);
          end
          if (a.consec) begin
            vectors++;
            if (cyc != last_rd_cyc + 1) begin
              miscompares++;
              $display("FAIL read_back_to_back: got cycle %0d, required %0d", cyc, last_rd_cyc + 1);
            end
          end
          if (!mem_wr) begin
            if (!a.consec) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
          end else begin
            last_wr_cyc = cyc;
          end
        end
      end else if (mem_wr || wr_done || mem_addr != 16'h0 || mem_data_in != 16'h0) begin
        vectors++;
        miscompares++;
        $display("FAIL idle_port: got wr=%b wr_done=%b addr=%h din=%h, required all 0",
                 mem_wr, wr_done, mem_addr, mem_data_in);
      end

      if (i_fill_valid || d_fill_valid) begin
        vectors++;
        if (fil_q.size() == 0) begin
          miscompares++;
          $display("FAIL fill_unexpected: got i=%b d=%b word=%0d data=%h, required none",
                   i_fill_valid, d_fill_valid, fill_word, fill_data);
        end else begin
          f = fil_q.pop_front();
          if ({i_fill_valid, d_fill_valid, fill_word, fill_data, i_fill_done, d_fill_done} !=
              {~f.d, f.d, f.word, f.data, f.done & ~f.d, f.done & f.d}) begin
            miscompares++;
            $display("FAIL fill: got i=%b d=%b word=%0d data=%h idone=%b ddone=%b, required i=%b d=%b word=%0d data=%h idone=%b ddone=%b",
                     i_fill_valid, d_fill_valid, fill_word, fill_data, i_fill_done, d_fill_done,
                     ~f.d, f.d, f.word, f.data, f.done & ~f.d, f.done & f.d);
          end
        end
      end else if (i_fill_done || d_fill_done) begin
        vectors++;
        miscompares++;
        $display("FAIL done_without_word: got idone=%b ddone=%b, required 0 0", i_fill_done, d_fill_done);
      end
    end
  end

  // Expected reads and returned words of one block fill starting at base.
  task automatic push_fill(input logic d, input logic [15:0] base);
    for (int k = 0; k < 8; k++) begin
      acc_q.push_back('{1'b0, base + 16'(2 * k), 16'h0, (k > 0)});
      fil_q.push_back('{d, 3'(k), (base + 16'(2 * k)) ^ 16'h5A5A, (k == 7)});
    end
  endtask

  task automatic push_wr(input logic [15:0] addr, input logic [15:0] data);
    acc_q.push_back('{1'b1, addr, data, 1'b0});
  endtask

  // which: 0 = i_fill_done, 1 = d_fill_done, 2 = wr_done
  task automatic wait_done(input int which, input int budget, output int at_cyc);
    bit seen = 0;
    at_cyc = -1;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      #2;
      case (which)
        0:       seen = i_fill_done;
        1:       seen = d_fill_done;
        default: seen = wr_done;
      endcase
      if (seen) at_cyc = cyc;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL done_timeout: got no pulse of kind %0d within %0d cycles, required one", which, budget);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [87:0] all_out;
    all_out = {mem_addr, mem_data_in, mem_enable, mem_wr, fill_data, i_fill_valid, d_fill_valid,
               fill_word, i_fill_done, d_fill_done, wr_done};
    vectors++;
    if (all_out != '0) begin
      miscompares++;
      $display("FAIL %s: got outputs %h, required 0", name, all_out);
    end
  endtask

  task automatic check_eq(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    int t_done, t_done2, t_wr;
    rst_n = 1'b0;
    icache_miss = 1'b0; dcache_miss = 1'b0; dcache_wr = 1'b0;
    icache_addr = '0; dcache_addr = '0; dcache_wr_data = '0;
    #12;
    check_outputs_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // I fill from 0x1236: base 0x1230.
    icache_addr = 16'h1236;
    icache_miss = 1'b1;
    push_fill(1'b0, 16'h1230);
    wait_done(0, 40, t_done);
    icache_miss = 1'b0;
    repeat (3) @(negedge clk);

    // Store to 0x0041: memory sees 0x0040.
    dcache_addr    = 16'h0041;
    dcache_wr_data = 16'hBEEF;
    dcache_wr      = 1'b1;
    push_wr(16'h0040, 16'hBEEF);
    wait_done(2, 10, t_wr);
    dcache_wr = 1'b0;
    repeat (3) @(negedge clk);

    // Simultaneous misses. The most recent fill was I, so D wins in both modes.
    icache_addr = 16'h00FF;
    dcache_addr = 16'h8F0F;
    icache_miss = 1'b1;
    dcache_miss = 1'b1;
    push_fill(1'b1, 16'h8F00);
    push_fill(1'b0, 16'h00F0);
    wait_done(1, 40, t_done);
    dcache_miss = 1'b0;
    wait_done(0, 40, t_done2);
    icache_miss = 1'b0;
    check_eq("idle_gap_between_fills", first_rd_cyc, t_done + 2);
    repeat (3) @(negedge clk);

    // Tie again. Fixed priority picks D; alternation picks D because I went last.
    icache_addr = 16'h0123;
    dcache_addr = 16'h0F1E;
    icache_miss = 1'b1;
    dcache_miss = 1'b1;
    push_fill(1'b1, 16'h0F10);
    push_fill(1'b0, 16'h0120);
    wait_done(1, 40, t_done);
    dcache_miss = 1'b0;
    wait_done(0, 40, t_done2);
    icache_miss = 1'b0;
    repeat (3) @(negedge clk);

    // Store arriving during an I fill waits for the fill to finish.
    icache_addr = 16'h4321;
    icache_miss = 1'b1;
    push_fill(1'b0, 16'h4320);
    repeat (3) @(negedge clk);
    dcache_addr    = 16'h7FFF;
    dcache_wr_data = 16'h1234;
    dcache_wr      = 1'b1;
    push_wr(16'h7FFE, 16'h1234);
    wait_done(0, 40, t_done);
    icache_miss = 1'b0;
    wait_done(2, 10, t_wr);
    dcache_wr = 1'b0;
    check_eq("write_after_fill_cycle", last_wr_cyc, t_done + 2);
    repeat (3) @(negedge clk);

    // Reset after the third word of an I fill.
    icache_addr = 16'h2000;
    icache_miss = 1'b1;
    push_fill(1'b0, 16'h2000);
    begin
      bit seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
        @(negedge clk);
        #2;
        seen = i_fill_valid && (fill_word == 3'd2);
      end
      check_eq("third_word_seen", int'(seen), 1);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    icache_miss = 1'b0;
    acc_q.delete();
    fil_q.delete();
    #1;
    check_outputs_zero("async_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20 && rd_q.size() > 0; n++) begin
      @(negedge clk);
      #2;
      if (mem_data_valid) begin
        check_eq("late_word_ignored", int'({i_fill_valid, d_fill_valid, i_fill_done}), 0);
      end
    end
    check_eq("stale_reads_drained", rd_q.size(), 0);
    repeat (3) @(negedge clk);

    icache_addr = 16'hABCD;
    icache_miss = 1'b1;
    push_fill(1'b0, 16'hABC0);
    wait_done(0, 40, t_done);
    icache_miss = 1'b0;
    repeat (6) @(negedge clk);

    check_eq("access_queue_empty", acc_q.size(), 0);
    check_eq("fill_queue_empty", fil_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by 100000, required earlier finish");
    $fatal(1, "watchdog");
  end

endmodule
